aes_128_ctr: RTL and testbench
==============================

Name: aes_128_ctr

Overview:
Iterative AES-128 encryption engine that computes one round per clock.
It runs in either ECB mode (encrypt the input block) or CTR mode (XOR the input block with the encryption of an internal counter block).
It has valid/ready handshakes on both the input and output streams, plus loadable key and IV registers.
It is the area-reduced, stream-capable successor to the fully unrolled AES-128 pipeline and reuses the team's round and key-expansion primitives.

Parameters:
CTR_W, 32, number of low bits of the counter block that increment per block (1..128); the upper 128-CTR_W bits never change.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
key_load  input  1  load key register from key (honoured only in IDLE)
key  input  128  AES-128 cipher key
iv_load  input  1  load counter register from iv and clear ctr_wrap (honoured only in IDLE)
iv  input  128  initial counter block
in_valid  input  1  input block valid
in_ready  output  1  engine can accept a block
in_data  input  128  plaintext block (CTR) or block to encrypt (ECB)
in_mode  input  1  0 = CTR, 1 = ECB; sampled on input handshake
out_valid  output  1  result valid; held until accepted
out_ready  input  1  downstream accepts result
out_data  output  128  result block
busy  output  1  high in ROUND or DONE
ctr_wrap  output  1  sticky: CTR-mode increment wrapped the low CTR_W bits

Behaviour:
- Reset values: state=IDLE; key, counter, out_data = 0; out_valid=0; ctr_wrap=0; round counter=0.
- in_ready = (state==IDLE) && !rst && !key_load && !iv_load.
- While rst is high, in_ready=0.
- Reset during ROUND or DONE aborts the block: no out_valid, and the counter does not advance beyond any increment already made.
- Key/IV loads:
  - key_load and iv_load take effect on the edge only when state==IDLE; otherwise they are ignored (not queued).
  - Both may be asserted together.
  - A load cycle blocks input acceptance in that cycle.
- FSM states: IDLE, ROUND, DONE.
  - IDLE -> ROUND on handshake (in_valid && in_ready).
    - At that edge, state <= (in_mode ? in_data : counter) ^ key.
    - in_data and in_mode are latched; round=1.
    - In CTR mode the counter increments at the same edge.
  - ROUND:
    - Each edge applies round r with round key r, generated on the fly from the previous round key with rcon sequence 01,02,04,08,10,20,40,80,1b,36.
    - Rounds 1..9 are full rounds; round 10 omits MixColumns.
    - After the round-10 edge: state -> DONE, out_valid=1.
    - out_data = latched in_data ^ keystream in CTR; ciphertext in ECB.
  - DONE:
    - out_data and out_valid are held stable until out_ready.
    - On out_valid && out_ready: out_valid <= 0, state -> IDLE.
- Latency: handshake at edge T gives out_valid high after edge T+10.
- Throughput: next accept no earlier than edge T+12 (with out_ready high at T+11).
- Counter increment: low CTR_W bits wrap mod 2^CTR_W. If they were all ones before the increment, ctr_wrap is set (sticky) and encryption continues with the wrapped value. ctr_wrap clears only on rst or an honoured iv_load.
- ECB mode leaves the counter unchanged.
- Changing the key input port mid-block has no effect; only the latched key register is used.

Test Plan:
1. ECB FIPS-197: key_load key=000102030405060708090a0b0c0d0e0f, in_mode=1, in_data=00112233445566778899aabbccddeeff -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after handshake.
2. CTR SP800-38A:
   - Setup: key=2b7e151628aed2a6abf7158809cf4f3c, iv=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff.
   - Block 1: in_data 6bc1bee22e409f96e93d7e117393172a -> 874d6191b620e3261bef6864990db6ce.
   - Block 2: ae2d8a571e03ac9c9eb76fac45af8e51 -> 9806f66b7970fdff8617187bb9fffdff.
   - Counter after block 1 = f0f1f2f3f4f5f6f7f8f9fafbfcfdff00.
3. Backpressure: out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0, second in_valid not accepted. Raise out_ready -> one transfer, then IDLE.
4. Wrap: CTR_W=32, iv low word ffffffff, one CTR block -> counter low word 00000000, upper 96 bits unchanged, ctr_wrap=1. Next iv_load clears it.
5. Ignored loads: key_load with a new key during ROUND -> current block and the following block still use the old key (FIPS vector output).
6. Reset mid-block: rst for 1 cycle at round 5 -> out_valid never asserts for that block, state IDLE, in_ready=1 the cycle after rst drops, key=0.

Source files
------------

// File: rtl/aes_128_ctr.sv
// Iterative AES-128 engine, one round per clock, ECB or CTR mode.
// The round key is expanded on the fly alongside the state, so only the
// key register, the current round key and the state are stored.
module aes_128_ctr #(
    parameter int CTR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] key,
    input  logic         iv_load,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic         ctr_wrap
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]   fsm;
    logic [3:0]   round;
    logic [127:0] st, rk, key_reg, counter, din, ctr_next, rk_next, round_out;
    logic         mode;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) plus the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] p, r;
        p = b;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte i of the block sits at [127-8*i -: 8]; column c holds bytes 4c..4c+3
    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
        logic [127:0] sb, sr, mc;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return (last ? sr : mc) ^ k;
    endfunction

    assign in_ready = (fsm == S_IDLE) && !rst && !key_load && !iv_load;
    assign busy     = (fsm == S_ROUND) || (fsm == S_DONE);

    // Next counter (only the low CTR_W bits move) and next round datapath
    always_comb begin
        ctr_next                = counter;
        ctr_next[CTR_W-1:0]     = counter[CTR_W-1:0] + CTR_W'(1);
        rk_next                 = key_step(rk, rcon(round));
        round_out               = round_fn(st, rk_next, round == 4'd10);
    end

    // Control FSM, key/IV registers and the iterated round state
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_IDLE;
            round     <= 4'd0;
            st        <= '0;
            rk        <= '0;
            key_reg   <= '0;
            counter   <= '0;
            din       <= '0;
            mode      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            ctr_wrap  <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (key_load) key_reg <= key;
                    if (iv_load) begin
                        counter  <= iv;
                        ctr_wrap <= 1'b0;
                    end
                    if (in_valid && in_ready) begin
                        st    <= (in_mode ? in_data : counter) ^ key_reg;
                        rk    <= key_reg;
                        din   <= in_data;
                        mode  <= in_mode;
                        round <= 4'd1;
                        fsm   <= S_ROUND;
                        if (!in_mode) begin
                            counter <= ctr_next;
                            if (&counter[CTR_W-1:0]) ctr_wrap <= 1'b1;
                        end
                    end
                end
                S_ROUND: begin
                    st <= round_out;
                    rk <= rk_next;
                    if (round == 4'd10) begin
                        fsm       <= S_DONE;
                        round     <= 4'd0;
                        out_valid <= 1'b1;
                        out_data  <= mode ? round_out : (din ^ round_out);
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_128_ctr.sv
// Self-checking bench for aes_128_ctr: known-answer table, corner-case
// sequences and randomized blocks against a byte-array AES reference model.
module tb_aes_128_ctr;
    localparam int CTR_W = 32;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] SP_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SP_IV    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

    logic         clk, rst, key_load, iv_load, in_valid, in_ready, in_mode;
    logic         out_valid, out_ready, busy, ctr_wrap;
    logic [127:0] key, iv, in_data, out_data;

    aes_128_ctr #(.CTR_W(CTR_W)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key(key), .iv_load(iv_load), .iv(iv),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .ctr_wrap(ctr_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [7:0]   sb[256];
    logic [127:0] m_key, m_ctr;
    logic         m_wrap;

    typedef struct {
        string        name;
        logic         kl;
        logic [127:0] k;
        logic         il;
        logic [127:0] v;
        logic         mode;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;
    vec_t vt[3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] m2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Build the S-box by walking the multiplicative group with generator 3
    function automatic void build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w[44];
        logic [31:0]  tmp;
        logic [7:0]   s[16], t[16], rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]] ^ rc, sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
                rc  = m2(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    t[0] = s[4*c]; t[1] = s[4*c+1]; t[2] = s[4*c+2]; t[3] = s[4*c+3];
                    s[4*c]   = m2(t[0]) ^ m2(t[1]) ^ t[1] ^ t[2] ^ t[3];
                    s[4*c+1] = t[0] ^ m2(t[1]) ^ m2(t[2]) ^ t[2] ^ t[3];
                    s[4*c+2] = t[0] ^ t[1] ^ m2(t[2]) ^ m2(t[3]) ^ t[3];
                    s[4*c+3] = m2(t[0]) ^ t[0] ^ t[1] ^ t[2] ^ m2(t[3]);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Expected result of one block; advances the model counter in CTR mode
    function automatic logic [127:0] model_block(input logic mode, input logic [127:0] d);
        logic [127:0] mask, ks;
        if (mode) return aes_ref(m_key, d);
        mask = (CTR_W == 128) ? '1 : ((128'd1 << CTR_W) - 128'd1);
        ks   = aes_ref(m_key, m_ctr);
        if ((m_ctr & mask) == mask) m_wrap = 1'b1;
        m_ctr = (m_ctr & ~mask) | ((m_ctr + 128'd1) & mask);
        return d ^ ks;
    endfunction

    task automatic do_load(input logic kl, input logic [127:0] k, input logic il,
                           input logic [127:0] v);
        @(negedge clk);
        key_load = kl; key = k; iv_load = il; iv = v;
        @(negedge clk);
        key_load = 1'b0; iv_load = 1'b0;
        if (kl) m_key = k;
        if (il) begin m_ctr = v; m_wrap = 1'b0; end
    endtask

    // One block through the engine; lat counts edges from handshake to out_valid
    task automatic run_block(input logic mode, input logic [127:0] d, input int hold,
                             output logic [127:0] res, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_mode = mode; in_data = d;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'd1);
            in_valid = 1'b0; res = 'x; lat = -1;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        res = out_data;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] res, exp, upper, nk;
        int           lat, n;
        logic         ok, kl, il, md;

        build_sbox();
        rst = 1'b1; key_load = 0; iv_load = 0; key = '0; iv = '0;
        in_valid = 0; in_mode = 0; in_data = '0; out_ready = 0;
        m_key = '0; m_ctr = '0; m_wrap = 1'b0;

        vt[0] = '{"ecb_fips197", 1'b1, FIPS_KEY, 1'b0, '0, 1'b1, FIPS_PT, FIPS_CT};
        vt[1] = '{"ctr_sp800_b1", 1'b1, SP_KEY, 1'b1, SP_IV, 1'b0,
                  128'h6bc1bee22e409f96e93d7e117393172a, 128'h874d6191b620e3261bef6864990db6ce};
        vt[2] = '{"ctr_sp800_b2", 1'b0, '0, 1'b0, '0, 1'b0,
                  128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h9806f66b7970fdff8617187bb9fffdff};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_ctr_wrap", 128'(ctr_wrap), 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 128'(in_ready), 128'd1);

        // known-answer table
        for (int i = 0; i < 3; i++) begin
            if (vt[i].kl || vt[i].il) do_load(vt[i].kl, vt[i].k, vt[i].il, vt[i].v);
            exp = model_block(vt[i].mode, vt[i].din);
            run_block(vt[i].mode, vt[i].din, 0, res, lat);
            chk(vt[i].name, res, vt[i].exp);
            chk({vt[i].name, "_lat"}, 128'(lat), 128'd10);
            if (i == 1) chk("ctr_after_b1", dut.counter, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
        end

        // backpressure: result held 20 cycles, second block refused
        do_load(1'b1, FIPS_KEY, 1'b0, '0);
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b1; in_data = FIPS_PT;
        @(posedge clk); #1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        repeat (9) @(posedge clk);
        #1;
        chk("bp_lat9_not_valid", 128'(out_valid), 128'd0);
        @(posedge clk); #1;
        chk("bp_lat10_valid", 128'(out_valid), 128'd1);
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (!out_valid || out_data !== FIPS_CT || in_ready || !busy) ok = 1'b0;
        end
        chk("bp_hold_stable", 128'(ok), 128'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_released", {out_valid, busy, in_ready}, 128'b001);

        // counter wrap: low word all ones
        upper = {$urandom, $urandom, $urandom, 32'h0};
        do_load(1'b1, SP_KEY, 1'b1, upper | 128'hffffffff);
        in_data = {$urandom, $urandom, $urandom, $urandom};
        exp = model_block(1'b0, in_data);
        run_block(1'b0, in_data, 0, res, lat);
        chk("wrap_data", res, exp);
        chk("wrap_counter", dut.counter, upper);
        chk("wrap_flag", 128'(ctr_wrap), 128'd1);
        do_load(1'b0, '0, 1'b1, SP_IV);
        chk("wrap_cleared", 128'(ctr_wrap), 128'd0);

        // key_load during ROUND is ignored
        do_load(1'b1, FIPS_KEY, 1'b0, '0);
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b1; in_data = FIPS_PT;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        nk = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        key_load = 1'b1; key = nk;
        @(negedge clk);
        key_load = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("kl_ignored_cur", out_data, FIPS_CT);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_block(1'b1, FIPS_PT, 0, res, lat);
        chk("kl_ignored_next", res, FIPS_CT);

        // reset at round 5 aborts the block
        @(negedge clk);
        in_valid = 1'b1; in_mode = 1'b1; in_data = FIPS_PT;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_in_ready", 128'(in_ready), 128'd1);
        chk("rstmid_busy", 128'(busy), 128'd0);
        chk("rstmid_key", dut.key_reg, 128'd0);
        ok = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (out_valid) ok = 1'b0;
        end
        chk("rstmid_no_out", 128'(ok), 128'd1);
        m_key = '0; m_ctr = '0; m_wrap = 1'b0;

        // randomized blocks against the reference model
        for (int i = 0; i < 24; i++) begin
            kl = (i == 0) || ($urandom_range(0, 3) == 0);
            il = (i == 0) || ($urandom_range(0, 3) == 0);
            nk = {$urandom, $urandom, $urandom, $urandom};
            upper = {$urandom, $urandom, $urandom,
                     ($urandom_range(0, 1) == 1) ? (32'hffffffff - 32'($urandom_range(0, 2))) : $urandom};
            if (kl || il) do_load(kl, nk, il, upper);
            md = 1'($urandom_range(0, 1));
            in_data = {$urandom, $urandom, $urandom, $urandom};
            exp = model_block(md, in_data);
            run_block(md, in_data, $urandom_range(0, 3), res, lat);
            chk($sformatf("rand%0d_data", i), res, exp);
            chk($sformatf("rand%0d_lat", i), 128'(lat), 128'd10);
            chk($sformatf("rand%0d_ctr", i), dut.counter, m_ctr);
            chk($sformatf("rand%0d_wrap", i), 128'(ctr_wrap), 128'(m_wrap));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
